edm_tx_sched: RTL and testbench

Frame-atomic round-robin scheduler that shares one PHY transmit lane among NQ net FIFOs. Each FIFO is 64b data plus a 2b sync header, with first-word-fall-through read data and rd/empty handshake. The scheduler reads the granted FIFO until a terminate control block, enforces an inter-frame idle gap, and fills all other slots with idle blocks. It sits between the per-port net FIFOs and the PHY encoder.

---
 rtl/edm_tx_sched.sv | 196 +++++++++++++++++++
 tb/tb_edm_tx_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edm_tx_sched.sv
// edm_tx_sched: shares one PHY transmit lane among NQ net FIFOs.
// Frames are sent whole: once a FIFO is granted it keeps the lane until a
// terminate control block has been loaded. A run of idle blocks follows
// every terminate, and any slot without data carries an idle block.
//
// Optional build macro: EDM_TX_SCHED_PRIO0_EN gives FIFO 0 strict priority
// at arbitration. Round-robin then covers only FIFOs 1..NQ-1, and frames
// from FIFO 0 leave the round-robin pointer alone.
//
// Handshakes: a FIFO head is consumed on a cycle where q_rd[i]=1. That is
// only allowed while q_empty[i]=0, and it always coincides with out_ready=1.
// The PHY side takes out_data_* on every cycle with out_ready=1. While
// out_ready=0 the output register holds, no FIFO is read and the FSM waits;
// the single exception is ARB, which still moves on to SEND.
module edm_tx_sched #(
  parameter int NQ = 4,
  parameter int DWIDTH = 64,
  parameter int CWIDTH = 2,
  parameter int MIN_IPG = 2,
  parameter logic [DWIDTH-1:0] IDLE_BLK = 64'h0000_0000_0000_001E
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NQ-1:0]             q_empty,
  input  logic [NQ*DWIDTH-1:0]      q_data_d,
  input  logic [NQ*CWIDTH-1:0]      q_data_c,
  output logic [NQ-1:0]             q_rd,
  input  logic                      out_ready,
  output logic [DWIDTH-1:0]         out_data_d,
  output logic [CWIDTH-1:0]         out_data_c,
  output logic [$clog2(NQ)-1:0]     grant_id,
  output logic                      busy,
  output logic                      underrun
);

  localparam int GW  = $clog2(NQ);
  localparam int GCW = $clog2(MIN_IPG + 1);
  localparam logic [CWIDTH-1:0] SYNC_CTRL = CWIDTH'(2'b01);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SEND, S_GAP} state_t;

  state_t            state;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     rr_next;
  logic              rr_upd;
  logic [GCW-1:0]    gap_cnt;
  logic              any_req;
  logic [DWIDTH-1:0] head_d;
  logic [CWIDTH-1:0] head_c;
  logic              head_empty;
  logic              is_term;
  logic [GW-1:0]     pick;
  logic              pick_vld;
  logic [GW-1:0]     cand;

  assign any_req    = |(~q_empty);
  assign head_empty = q_empty[grant_id];
  // Terminate is a control block whose type byte is above 0x86 (unsigned).
  assign is_term    = (head_c == SYNC_CTRL) && (head_d[7:0] > 8'h86);
  assign rr_next    = (grant_id == GW'(NQ - 1)) ? '0 : grant_id + 1'b1;

  // Select the head block of the granted FIFO.
  always_comb begin
    head_d = q_data_d[DWIDTH-1:0];
    head_c = q_data_c[CWIDTH-1:0];
    for (int i = 0; i < NQ; i++) begin
      if (grant_id == GW'(i)) begin
        head_d = q_data_d[i*DWIDTH +: DWIDTH];
        head_c = q_data_c[i*CWIDTH +: CWIDTH];
      end
    end
  end

  // Read strobe: only the granted FIFO, only while sending and the PHY takes data.
  always_comb begin
    q_rd = '0;
    if (state == S_SEND && out_ready && !head_empty) begin
      q_rd[grant_id] = 1'b1;
    end
  end

`ifdef EDM_TX_SCHED_PRIO0_EN
  int base;

  // FIFO 0 wins outright; the others share round-robin order starting at rr_ptr.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    base     = (rr_ptr == '0) ? 1 : int'(rr_ptr);
    for (int k = 0; k < NQ - 1; k++) begin
      cand = GW'(1 + ((base - 1 + k) % (NQ - 1)));
      if (!pick_vld && !q_empty[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
    if (!q_empty[0]) begin
      pick     = '0;
      pick_vld = 1'b1;
    end
  end

  assign rr_upd = (grant_id != '0);
`else
  // Pure round-robin: first non-empty FIFO scanning from rr_ptr upward, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 0; k < NQ; k++) begin
      cand = GW'((int'(rr_ptr) + k) % NQ);
      if (!pick_vld && !q_empty[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign rr_upd = 1'b1;
`endif

  // Scheduler FSM with registered output block, grant, busy and underrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      out_data_c <= SYNC_CTRL;
      out_data_d <= IDLE_BLK;
      grant_id   <= '0;
      rr_ptr     <= '0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      underrun <= 1'b0;
      case (state)
        S_IDLE: begin
          if (out_ready) begin
            out_data_c <= SYNC_CTRL;
            out_data_d <= IDLE_BLK;
            if (any_req) state <= S_ARB;
          end
        end
        S_ARB: begin
          if (out_ready) begin
            out_data_c <= SYNC_CTRL;
            out_data_d <= IDLE_BLK;
          end
          if (pick_vld) begin
            grant_id <= pick;
            busy     <= 1'b1;
            state    <= S_SEND;
          end else if (out_ready) begin
            state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (head_empty) begin
              // Starved mid-frame: keep the lane, fill with idle, flag it.
              out_data_c <= SYNC_CTRL;
              out_data_d <= IDLE_BLK;
              underrun   <= 1'b1;
            end else begin
              out_data_c <= head_c;
              out_data_d <= head_d;
              if (is_term) begin
                if (rr_upd) rr_ptr <= rr_next;
                gap_cnt <= GCW'(MIN_IPG);
                busy    <= 1'b0;
                state   <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (out_ready) begin
            out_data_c <= SYNC_CTRL;
            out_data_d <= IDLE_BLK;
            if (gap_cnt <= GCW'(1)) begin
              gap_cnt <= '0;
              state   <= any_req ? S_ARB : S_IDLE;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edm_tx_sched.sv
// tb_edm_tx_sched: directed checks of edm_tx_sched in its default build.
// The FIFOs are modelled by small circular buffers. A head is popped on the
// cycle where q_rd was high just before the clock edge.
`timescale 1ns/1ps
module tb_edm_tx_sched;

  localparam int NQ = 4;
  localparam int DW = 64;
  localparam int CW = 2;
  localparam logic [1:0]  SD = 2'b10;
  localparam logic [1:0]  SC = 2'b01;
  localparam logic [63:0] IDLE_D = 64'h0000_0000_0000_001E;
  localparam logic [65:0] IDLE_W = {SC, IDLE_D};

  // Data and control words used by the tests
  localparam logic [63:0] W_A   = 64'hA1A1_A1A1_A1A1_A1A1;
  localparam logic [63:0] W_B   = 64'hB2B2_B2B2_B2B2_B2B2;
  localparam logic [63:0] W_C   = 64'hC3C3_C3C3_C3C3_C3C3;
  localparam logic [63:0] W_D   = 64'hD4D4_D4D4_D4D4_D4D4;
  localparam logic [63:0] W_E   = 64'hE5E5_E5E5_E5E5_E5E5;
  localparam logic [63:0] T87   = 64'h1111_2222_3333_4487;
  localparam logic [63:0] TFF   = 64'h5555_6666_7777_88FF;
  localparam logic [63:0] C86   = 64'h9999_AAAA_BBBB_CC86;

  logic                 clk;
  logic                 reset;
  logic [NQ-1:0]        q_empty;
  logic [NQ*DW-1:0]     q_data_d;
  logic [NQ*CW-1:0]     q_data_c;
  logic [NQ-1:0]        q_rd;
  logic                 out_ready;
  logic [DW-1:0]        out_data_d;
  logic [CW-1:0]        out_data_c;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 underrun;

  logic [65:0] fmem [NQ][16];
  int          wp [NQ];
  int          rp [NQ];
  logic [NQ-1:0] rd_snap;

  logic [65:0] exp_q [$];
  int n_cmp;
  int n_err;

  edm_tx_sched dut (
    .clk        (clk),
    .reset      (reset),
    .q_empty    (q_empty),
    .q_data_d   (q_data_d),
    .q_data_c   (q_data_c),
    .q_rd       (q_rd),
    .out_ready  (out_ready),
    .out_data_d (out_data_d),
    .out_data_c (out_data_c),
    .grant_id   (grant_id),
    .busy       (busy),
    .underrun   (underrun)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic refresh();
    for (int i = 0; i < NQ; i++) begin
      q_empty[i] = (wp[i] == rp[i]);
      q_data_c[i*CW +: CW] = fmem[i][rp[i] % 16][65:64];
      q_data_d[i*DW +: DW] = fmem[i][rp[i] % 16][63:0];
    end
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NQ; i++) begin
      wp[i] = 0;
      rp[i] = 0;
      for (int j = 0; j < 16; j++) fmem[i][j] = '0;
    end
    refresh();
  endtask

  task automatic push(input int i, input logic [1:0] c, input logic [63:0] d);
    fmem[i][wp[i] % 16] = {c, d};
    wp[i] = wp[i] + 1;
    refresh();
  endtask

  // One clock: snapshot q_rd before the edge, pop consumed heads after it.
  task automatic tick();
    @(negedge clk);
    rd_snap = q_rd;
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (rd_snap[i] && rp[i] != wp[i]) rp[i] = rp[i] + 1;
    end
    refresh();
  endtask

  task automatic do_reset();
    out_ready = 1'b1;
    clear_fifos();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if ({out_data_c, out_data_d} !== IDLE_W) begin n_err++;
      $display("FAIL reset out: got %h want %h", {out_data_c, out_data_d}, IDLE_W); end
    n_cmp++; if (grant_id !== 2'd0) begin n_err++;
      $display("FAIL reset grant: got %0d want 0", grant_id); end
    n_cmp++; if (busy !== 1'b0 || underrun !== 1'b0) begin n_err++;
      $display("FAIL reset busy/underrun: got %b%b want 00", busy, underrun); end
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if ({out_data_c, out_data_d} !== IDLE_W) begin n_err++;
        $display("FAIL reset idle c%0d: got %h want %h", c, {out_data_c, out_data_d}, IDLE_W); end
      n_cmp++; if (rd_snap !== 4'h0 || busy !== 1'b0) begin n_err++;
        $display("FAIL reset rd/busy c%0d: got %h/%b want 0/0", c, rd_snap, busy); end
    end
  endtask

  task automatic test_single_frame();
    logic [65:0] exp_blk;
    logic [3:0] rd_tab [8] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};
    logic       bz_tab [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    push(2, SD, W_A); push(2, SD, W_B); push(2, SC, T87);
    exp_q.delete();
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    exp_q.push_back({SD, W_A}); exp_q.push_back({SD, W_B}); exp_q.push_back({SC, T87});
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    for (int c = 0; c < 8; c++) begin
      tick();
      exp_blk = exp_q.pop_front();
      n_cmp++; if ({out_data_c, out_data_d} !== exp_blk) begin n_err++;
        $display("FAIL single_frame blk c%0d: got %h want %h", c, {out_data_c, out_data_d}, exp_blk); end
      n_cmp++; if (rd_snap !== rd_tab[c]) begin n_err++;
        $display("FAIL single_frame q_rd c%0d: got %h want %h", c, rd_snap, rd_tab[c]); end
      n_cmp++; if (busy !== bz_tab[c] || underrun !== 1'b0) begin n_err++;
        $display("FAIL single_frame busy/underrun c%0d: got %b%b want %b0", c, busy, underrun, bz_tab[c]); end
      if (c >= 1) begin
        n_cmp++; if (grant_id !== 2'd2) begin n_err++;
          $display("FAIL single_frame grant c%0d: got %0d want 2", c, grant_id); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [65:0] exp_blk;
    logic [3:0] rd_tab [22] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2,
                                4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
    logic [1:0] gr_tab [22] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1,
                                2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    logic       bz_tab [22] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    // Control block with type 0x86 sits just below the terminate threshold.
    push(0, SC, C86); push(0, SD, W_B); push(0, SC, TFF);
    push(1, SD, W_C); push(1, SD, W_D); push(1, SC, T87);
    exp_q.delete();
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    exp_q.push_back({SC, C86}); exp_q.push_back({SD, W_B}); exp_q.push_back({SC, TFF});
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    exp_q.push_back({SD, W_C}); exp_q.push_back({SD, W_D}); exp_q.push_back({SC, T87});
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    exp_q.push_back({SD, W_E}); exp_q.push_back({SC, T87});
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    exp_q.push_back({SD, W_A}); exp_q.push_back({SC, TFF});
    for (int c = 0; c < 22; c++) begin
      tick();
      exp_blk = exp_q.pop_front();
      n_cmp++; if ({out_data_c, out_data_d} !== exp_blk) begin n_err++;
        $display("FAIL round_robin blk c%0d: got %h want %h", c, {out_data_c, out_data_d}, exp_blk); end
      n_cmp++; if (rd_snap !== rd_tab[c]) begin n_err++;
        $display("FAIL round_robin q_rd c%0d: got %h want %h", c, rd_snap, rd_tab[c]); end
      n_cmp++; if (grant_id !== gr_tab[c]) begin n_err++;
        $display("FAIL round_robin grant c%0d: got %0d want %0d", c, grant_id, gr_tab[c]); end
      n_cmp++; if (busy !== bz_tab[c]) begin n_err++;
        $display("FAIL round_robin busy c%0d: got %b want %b", c, busy, bz_tab[c]); end
      // rr_ptr is now 2: FIFO 3 must win over FIFO 0.
      if (c == 12) begin
        push(0, SD, W_A); push(0, SC, TFF);
        push(3, SD, W_E); push(3, SC, T87);
      end
    end
  endtask

  task automatic test_underrun();
    logic [65:0] exp_blk;
    logic [3:0] rd_tab [10] = '{4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0};
    logic       ur_tab [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       bz_tab [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    push(1, SD, W_A);
    exp_q.delete();
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W); exp_q.push_back({SD, W_A});
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    exp_q.push_back({SD, W_B}); exp_q.push_back({SC, T87});
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    for (int c = 0; c < 10; c++) begin
      tick();
      exp_blk = exp_q.pop_front();
      n_cmp++; if ({out_data_c, out_data_d} !== exp_blk) begin n_err++;
        $display("FAIL underrun blk c%0d: got %h want %h", c, {out_data_c, out_data_d}, exp_blk); end
      n_cmp++; if (rd_snap !== rd_tab[c]) begin n_err++;
        $display("FAIL underrun q_rd c%0d: got %h want %h", c, rd_snap, rd_tab[c]); end
      n_cmp++; if (underrun !== ur_tab[c]) begin n_err++;
        $display("FAIL underrun pulse c%0d: got %b want %b", c, underrun, ur_tab[c]); end
      n_cmp++; if (busy !== bz_tab[c]) begin n_err++;
        $display("FAIL underrun busy c%0d: got %b want %b", c, busy, bz_tab[c]); end
      if (c >= 1) begin
        n_cmp++; if (grant_id !== 2'd1) begin n_err++;
          $display("FAIL underrun grant c%0d: got %0d want 1", c, grant_id); end
      end
      if (c == 5) begin
        push(1, SD, W_B); push(1, SC, T87);
      end
    end
  endtask

  task automatic test_ready_stall();
    logic [65:0] exp_blk;
    logic [3:0] rd_tab [12] = '{4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    do_reset();
    push(2, SD, W_A); push(2, SD, W_B); push(2, SD, W_C); push(2, SC, T87);
    exp_q.delete();
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W); exp_q.push_back({SD, W_A});
    for (int k = 0; k < 4; k++) exp_q.push_back({SD, W_A});
    exp_q.push_back({SD, W_B}); exp_q.push_back({SD, W_C}); exp_q.push_back({SC, T87});
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    for (int c = 0; c < 12; c++) begin
      tick();
      exp_blk = exp_q.pop_front();
      n_cmp++; if ({out_data_c, out_data_d} !== exp_blk) begin n_err++;
        $display("FAIL ready_stall blk c%0d: got %h want %h", c, {out_data_c, out_data_d}, exp_blk); end
      n_cmp++; if (rd_snap !== rd_tab[c] || underrun !== 1'b0) begin n_err++;
        $display("FAIL ready_stall q_rd/underrun c%0d: got %h/%b want %h/0", c, rd_snap, underrun, rd_tab[c]); end
      if (c >= 2 && c <= 6) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++;
          $display("FAIL ready_stall busy c%0d: got %b want 1", c, busy); end
      end
      if (c == 2) out_ready = 1'b0;
      if (c == 6) out_ready = 1'b1;
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    push(2, SD, W_A); push(2, SC, T87);
    repeat (7) tick();
    push(3, SD, W_A); push(3, SD, W_B); push(3, SD, W_C); push(3, SD, W_D); push(3, SC, T87);
    repeat (4) tick();
    n_cmp++; if ({out_data_c, out_data_d} !== {SD, W_B} || grant_id !== 2'd3) begin n_err++;
      $display("FAIL reset_mid pre: got %h g%0d want %h g3", {out_data_c, out_data_d}, grant_id, {SD, W_B}); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({out_data_c, out_data_d} !== IDLE_W) begin n_err++;
      $display("FAIL reset_mid out: got %h want %h", {out_data_c, out_data_d}, IDLE_W); end
    n_cmp++; if (grant_id !== 2'd0 || busy !== 1'b0 || underrun !== 1'b0 || q_rd !== 4'h0) begin n_err++;
      $display("FAIL reset_mid ctl: got g%0d b%b u%b rd%h want g0 b0 u0 rd0", grant_id, busy, underrun, q_rd); end
    n_cmp++; if (wp[3] - rp[3] !== 3) begin n_err++;
      $display("FAIL reset_mid fifo3 level: got %0d want 3", wp[3] - rp[3]); end
    push(1, SD, W_E); push(1, SC, TFF);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (grant_id !== 2'd1 || busy !== 1'b1) begin n_err++;
      $display("FAIL reset_mid regrant: got g%0d b%b want g1 b1", grant_id, busy); end
    tick();
    n_cmp++; if ({out_data_c, out_data_d} !== {SD, W_E}) begin n_err++;
      $display("FAIL reset_mid first blk: got %h want %h", {out_data_c, out_data_d}, {SD, W_E}); end
  endtask

  task automatic test_back_to_back();
    logic [65:0] exp_blk;
    logic [3:0] rd_tab [17] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2,
                                4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    logic [1:0] gr_tab [17] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                                2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    do_reset();
    push(0, SD, W_A); push(0, SC, T87); push(0, SD, W_B); push(0, SC, TFF);
    push(1, SD, W_C); push(1, SC, T87);
    exp_q.delete();
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    exp_q.push_back({SD, W_A}); exp_q.push_back({SC, T87});
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    exp_q.push_back({SD, W_C}); exp_q.push_back({SC, T87});
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    exp_q.push_back({SD, W_B}); exp_q.push_back({SC, TFF});
    exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W); exp_q.push_back(IDLE_W);
    for (int c = 0; c < 17; c++) begin
      tick();
      exp_blk = exp_q.pop_front();
      n_cmp++; if ({out_data_c, out_data_d} !== exp_blk) begin n_err++;
        $display("FAIL back_to_back blk c%0d: got %h want %h", c, {out_data_c, out_data_d}, exp_blk); end
      n_cmp++; if (rd_snap !== rd_tab[c]) begin n_err++;
        $display("FAIL back_to_back q_rd c%0d: got %h want %h", c, rd_snap, rd_tab[c]); end
      n_cmp++; if (grant_id !== gr_tab[c]) begin n_err++;
        $display("FAIL back_to_back grant c%0d: got %0d want %0d", c, grant_id, gr_tab[c]); end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    out_ready = 1'b1;
    rd_snap = '0;
    q_empty = '1;
    q_data_d = '0;
    q_data_c = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_underrun();
    test_ready_stall();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
